// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types for the mips_pipeline hazard unit
package mips_pkg;

  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

endpackage

// File: rtl/mdu_scoreboard.sv
// rtl/mdu_scoreboard.sv - tracks the single outstanding multi-cycle mult/div op
// MduDoneW pulses in the last busy cycle, when the result leaves on the MDU write port.
module mdu_scoreboard
  import mips_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int MDU_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MduStartE,
  input  logic [REG_AW-1:0] MduDstE,
  output logic              MduBusy,
  output logic              MduDoneW,
  output logic [REG_AW-1:0] MduDst,
  output logic [3:0]        cnt
);

  mdu_state_t        r_state;
  logic [3:0]        r_cnt;
  logic [REG_AW-1:0] r_dst;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= MDU_IDLE;
      r_cnt   <= '0;
      r_dst   <= '0;
    end else begin
      case (r_state)
        MDU_IDLE: begin
          if (MduStartE) begin
            r_state <= MDU_BUSY;
            r_cnt   <= 4'(MDU_LAT - 1);
            r_dst   <= MduDstE;
          end
        end
        MDU_BUSY: begin
          // A start while busy is dropped; the stall on MduIssueD should prevent it.
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= MDU_IDLE;
          end
        end
        default: r_state <= MDU_IDLE;
      endcase
    end
  end

  assign MduBusy  = (r_state == MDU_BUSY);
  assign MduDoneW = (r_state == MDU_BUSY) && (r_cnt == 4'd0);
  assign MduDst   = r_dst;
  assign cnt      = r_cnt;

  a_no_start_while_busy : assert property (
    @(posedge clk) disable iff (!reset) !(MduStartE && (r_state == MDU_BUSY))
  );

endmodule

// File: rtl/hazard_unit_mdu.sv
// rtl/hazard_unit_mdu.sv - stall/flush/forward control for the 5-stage pipe plus MDU scoreboard
// HAZARD_FWD_EN selects forwarding; undefined, every in-flight RAW dependence stalls instead.
module hazard_unit_mdu
  import mips_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int MDU_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic              BranchD,
  input  logic              MduIssueD,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              MduStartE,
  input  logic [REG_AW-1:0] MduDstE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic              MduBusy,
  output logic              MduDoneW,
  output logic [REG_AW-1:0] MduDst
);

  logic       w_hit_e, w_hit_m, w_lwstall, w_brstall, w_mdustall, w_depstall, w_stall;
  fwd_sel_t   w_fwd_ae, w_fwd_be;
  logic       w_fwd_ad, w_fwd_bd;
  logic [3:0] w_cnt;

  function automatic logic f_match(input logic [REG_AW-1:0] x, input logic [REG_AW-1:0] y);
    return (x != '0) && (x == y);
  endfunction

  function automatic fwd_sel_t f_fwd_e(input logic [REG_AW-1:0] src);
    if (RegWriteM && f_match(src, WriteRegM)) return FWD_MEM;
    if (RegWriteW && f_match(src, WriteRegW)) return FWD_WB;
    return FWD_NONE;
  endfunction

  mdu_scoreboard #(
    .REG_AW (REG_AW),
    .MDU_LAT(MDU_LAT)
  ) u_mdu_sb (
    .clk      (clk),
    .reset    (reset),
    .MduStartE(MduStartE),
    .MduDstE  (MduDstE),
    .MduBusy  (MduBusy),
    .MduDoneW (MduDoneW),
    .MduDst   (MduDst),
    .cnt      (w_cnt)
  );

  assign w_hit_e    = f_match(RsD, WriteRegE) || f_match(RtD, WriteRegE);
  assign w_hit_m    = f_match(RsD, WriteRegM) || f_match(RtD, WriteRegM);
  assign w_lwstall  = MemtoRegE && w_hit_e;
  assign w_brstall  = BranchD && ((RegWriteE && w_hit_e) || (MemtoRegM && w_hit_m));
  assign w_mdustall = MduBusy && !MduDoneW &&
                      (f_match(RsD, MduDst) || f_match(RtD, MduDst) || MduIssueD);

`ifdef HAZARD_FWD_EN
  assign w_depstall = 1'b0;
  assign w_fwd_ae   = f_fwd_e(RsE);
  assign w_fwd_be   = f_fwd_e(RtE);
  assign w_fwd_ad   = RegWriteM && f_match(RsD, WriteRegM);
  assign w_fwd_bd   = RegWriteM && f_match(RtD, WriteRegM);
`else
  // Without bypass paths, any pending E/M writer of a D source must drain to W first.
  assign w_depstall = (RegWriteE && w_hit_e) || (RegWriteM && w_hit_m);
  assign w_fwd_ae   = FWD_NONE;
  assign w_fwd_be   = FWD_NONE;
  assign w_fwd_ad   = 1'b0;
  assign w_fwd_bd   = 1'b0;
`endif

  assign w_stall   = reset && (w_lwstall || w_brstall || w_mdustall || w_depstall);
  assign StallF    = w_stall;
  assign StallD    = w_stall;
  assign FlushE    = w_stall;
  assign ForwardAE = reset ? w_fwd_ae : FWD_NONE;
  assign ForwardBE = reset ? w_fwd_be : FWD_NONE;
  assign ForwardAD = reset && w_fwd_ad;
  assign ForwardBD = reset && w_fwd_bd;

endmodule
